// File: rtl/uart_slave_fifo.sv
// uart_slave_fifo: byte-wide bus slave UART with RX/TX FIFOs.
// 8N1 framing with a programmable 16-bit clocks-per-bit divisor.
module uart_slave_fifo_buf #(
  parameter int W = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  logic [7:0] mem [(1<<W)];
  logic [W:0] wr_ptr;
  logic [W:0] rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[W] != rd_ptr[W]) &&
                (wr_ptr[W-1:0] == rd_ptr[W-1:0]);
  assign head = mem[rd_ptr[W-1:0]];
  assign do_pop = pop && !empty;
  // a pop frees the slot, so a full FIFO still takes a push that cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (W+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (W+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[W-1:0]] <= din;
  end
endmodule

module uart_slave_fifo #(
  parameter int SYS_FREQ      = 25000000,
  parameter int BAUDRATE      = 115200,
  parameter int RX_DEPTH_LOG2 = 3,
  parameter int TX_DEPTH_LOG2 = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_addr,
  input  logic [7:0] i_dat,
  output logic [7:0] o_dat,
  input  logic       i_we,
  input  logic       i_cs,
  output logic       o_ack,
  output logic       o_int,
  input  logic       i_uart_rx,
  output logic       o_uart_tx
);
  localparam logic [15:0] DIV_RST = 16'(SYS_FREQ / BAUDRATE);

  typedef enum logic {TX_IDLE, TX_RUN} tx_st_t;
  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_t;

  logic [15:0] div_reg;
  logic [15:0] div_eff;
  logic [2:0]  ie;
  logic        ferr;
  logic        overrun;
  logic        acc;
  logic        rd_acc;
  logic        wr_acc;
  logic        clr_wr;
  logic [7:0]  rdata;

  logic [7:0]  rx_head;
  logic [7:0]  tx_head;
  logic        rx_full;
  logic        rx_empty;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_pop;
  logic        tx_push;
  logic        tx_pop;

  tx_st_t      tx_st;
  logic [15:0] tx_div;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_idx;
  logic [8:0]  tx_sh;
  logic        tx_busy;
  logic        tx_end;

  rx_st_t      rx_st;
  logic [15:0] rx_div;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_sh;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic        rx_bit;
  logic        rx_ok;
  logic        rx_bad;

  assign div_eff = (div_reg < 16'd4) ? 16'd4 : div_reg;
  assign acc = i_cs && !o_ack;
  assign rd_acc = acc && !i_we;
  assign wr_acc = acc && i_we;
  assign clr_wr = wr_acc && (i_addr == 3'd0);
  assign rx_pop = rd_acc && (i_addr == 3'd1);
  assign tx_push = wr_acc && (i_addr == 3'd1);

  assign tx_end = (tx_st == TX_RUN) && (tx_idx == 4'd9) &&
                  (tx_cnt == tx_div - 16'd1);
  assign tx_pop = !tx_empty && ((tx_st == TX_IDLE) || tx_end);

  assign rx_bit = rx_cnt == rx_div - 16'd1;
  assign rx_ok = (rx_st == RX_STOP) && rx_bit && rx_s2;
  assign rx_bad = (rx_st == RX_STOP) && rx_bit && !rx_s2;

  uart_slave_fifo_buf #(.W(RX_DEPTH_LOG2)) u_rxf (
    .i_clk(i_clk), .i_reset(i_reset),
    .push(rx_ok), .din(rx_sh), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  uart_slave_fifo_buf #(.W(TX_DEPTH_LOG2)) u_txf (
    .i_clk(i_clk), .i_reset(i_reset),
    .push(tx_push), .din(i_dat), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_comb begin
    rdata = 8'h00;
    unique case (i_addr)
      3'd0: rdata = {ferr, overrun, tx_busy, tx_full,
                     tx_empty, rx_full, rx_empty, 1'b0};
      3'd1: rdata = rx_empty ? 8'h00 : rx_head;
      3'd2: rdata = {5'b0, ie};
      3'd3: rdata = div_reg[7:0];
      3'd4: rdata = div_reg[15:8];
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ack   <= 1'b0;
      o_dat   <= 8'h00;
      o_int   <= 1'b0;
      ie      <= 3'b0;
      div_reg <= DIV_RST;
      ferr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      o_ack <= acc;
      o_dat <= rd_acc ? rdata : 8'h00;
      o_int <= |(ie & {ferr | overrun, tx_empty, !rx_empty});
      // a same-cycle set beats the clear
      ferr <= rx_bad | (ferr & !(clr_wr && i_dat[7]));
      overrun <= (rx_ok && rx_full && !rx_pop) |
                 (overrun & !(clr_wr && i_dat[6]));
      if (wr_acc) begin
        unique case (i_addr)
          3'd2: ie <= i_dat[2:0];
          3'd3: div_reg[7:0] <= i_dat;
          3'd4: div_reg[15:8] <= i_dat;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_st     <= TX_IDLE;
      o_uart_tx <= 1'b1;
      tx_busy   <= 1'b0;
      tx_div    <= 16'd4;
      tx_cnt    <= 16'd0;
      tx_idx    <= 4'd0;
      tx_sh     <= '1;
    end else if (tx_pop) begin
      tx_st     <= TX_RUN;
      tx_busy   <= 1'b1;
      o_uart_tx <= 1'b0;
      tx_sh     <= {1'b1, tx_head};
      tx_div    <= div_eff;
      tx_cnt    <= 16'd0;
      tx_idx    <= 4'd0;
    end else if (tx_st == TX_RUN) begin
      if (tx_cnt == tx_div - 16'd1) begin
        tx_cnt <= 16'd0;
        if (tx_idx == 4'd9) begin
          tx_st     <= TX_IDLE;
          tx_busy   <= 1'b0;
          o_uart_tx <= 1'b1;
        end else begin
          o_uart_tx <= tx_sh[0];
          tx_sh     <= {1'b1, tx_sh[8:1]};
          tx_idx    <= tx_idx + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_div  <= 16'd4;
      rx_cnt  <= 16'd0;
      rx_idx  <= 3'd0;
      rx_sh   <= 8'h00;
    end else begin
      rx_s1   <= i_uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_cnt  <= rx_cnt + 16'd1;
      unique case (rx_st)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_st  <= RX_START;
            rx_cnt <= 16'd0;
            rx_div <= div_eff;
          end
        end
        RX_START: begin
          // a start bit that is high again at mid-bit was a glitch
          if (rx_cnt == (rx_div >> 1)) begin
            rx_cnt <= 16'd0;
            rx_idx <= 3'd0;
            rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_bit) begin
            rx_cnt <= 16'd0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_idx <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_st <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_bit) begin
            rx_cnt <= 16'd0;
            rx_st  <= RX_IDLE;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_slave_fifo.sv
// tb_uart_slave_fifo: directed bench with a byte-level UART/FIFO model,
// a cycle-exact serial frame checker and a bus read scoreboard.
module tb_uart_slave_fifo;
  localparam int RXD = 2;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [2:0] i_addr;
  logic [7:0] i_dat;
  logic [7:0] o_dat;
  logic       i_we;
  logic       i_cs;
  logic       o_ack;
  logic       o_int;
  logic       i_uart_rx;
  logic       o_uart_tx;

  always #5 i_clk = ~i_clk;

  uart_slave_fifo #(
    .SYS_FREQ(25000000), .BAUDRATE(115200),
    .RX_DEPTH_LOG2(1), .TX_DEPTH_LOG2(3)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_addr(i_addr), .i_dat(i_dat), .o_dat(o_dat),
    .i_we(i_we), .i_cs(i_cs), .o_ack(o_ack), .o_int(o_int),
    .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic       ferr_m = 1'b0;
  logic       ovr_m = 1'b0;
  logic [2:0] ie_m = 3'b0;
  int         tx_div = 217;
  bit         gapchk = 1'b0;
  int         burst = 0;
  int         frames = 0;
  bit         chk_rd = 1'b0;
  logic [7:0] exp_rd = 8'h00;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] status_m(input logic busy,
                                          input logic full,
                                          input logic empty);
    return {ferr_m, ovr_m, busy, full, empty,
            rxq.size() == RXD, rxq.size() == 0, 1'b0};
  endfunction

  function automatic logic int_m(input logic txe);
    return |(ie_m & {ferr_m | ovr_m, txe, rxq.size() != 0});
  endfunction

  always @(negedge i_clk) begin
    if (chk_rd && o_ack) check("rdata", o_dat, exp_rd);
  end

  task automatic bus(input logic we, input logic [2:0] a,
                     input logic [7:0] d, input logic [7:0] exp);
    @(negedge i_clk);
    i_cs = 1'b1; i_we = we; i_addr = a; i_dat = d;
    exp_rd = exp; chk_rd = !we;
    @(negedge i_clk);
    check("ack", o_ack, 1);
    #1;
    i_cs = 1'b0; i_we = 1'b0; chk_rd = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 8'h00);
    if (a == 3'd0) begin
      if (d[7]) ferr_m = 1'b0;
      if (d[6]) ovr_m = 1'b0;
    end
    if (a == 3'd2) ie_m = d[2:0];
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp);
    bus(1'b0, a, 8'h00, exp);
  endtask

  task automatic rd_data();
    logic [7:0] e;
    e = 8'h00;
    if (rxq.size() != 0) e = rxq.pop_front();
    rd(3'd1, e);
  endtask

  task automatic send(input logic [7:0] b, input logic stop,
                      input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      i_uart_rx = f[i];
      repeat (div - 1) @(negedge i_clk);
    end
    @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (4) @(negedge i_clk);
    if (!stop) ferr_m = 1'b1;
    else if (rxq.size() == RXD) ovr_m = 1'b1;
    else rxq.push_back(b);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frames < target && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    check("tx_frames", frames, target);
  endtask

  initial begin : tx_mon
    int idle_n;
    int d;
    bit unexp;
    bit ab;
    logic [9:0] f;
    logic [7:0] b;
    idle_n = 0;
    forever begin
      @(negedge i_clk);
      if (i_reset || o_uart_tx !== 1'b0) begin
        idle_n++;
      end else begin
        d = tx_div;
        ab = 1'b0;
        unexp = txq.size() == 0;
        f = '1;
        if (unexp) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_frame: got unexpected start bit, want idle");
        end else begin
          b = txq.pop_front();
          f = {1'b1, b, 1'b0};
        end
        if (gapchk && burst > 0) check("tx_gap", idle_n, 0);
        burst++;
        idle_n = 0;
        for (int c = 0; c < 10 * d && !ab; c++) begin
          if (c > 0) @(negedge i_clk);
          if (i_reset) ab = 1'b1;
          else if (!unexp) check("tx_line", o_uart_tx, f[c / d]);
        end
        if (!ab) frames++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, want finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic [7:0] b;
    i_reset = 1'b1; i_cs = 1'b0; i_we = 1'b0;
    i_addr = 3'd0; i_dat = 8'h00; i_uart_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_tx", o_uart_tx, 1);
    check("rst_ack", o_ack, 0);
    check("rst_int", o_int, 0);
    check("rst_dat", o_dat, 0);
    i_reset = 1'b0;
    rd(3'd0, 8'h0A);
    rd(3'd3, 8'hD9);
    rd(3'd4, 8'h00);
    rd(3'd2, 8'h00);
    rd(3'd5, 8'h00);
    wr(3'd7, 8'hFF);
    rd(3'd7, 8'h00);
    rd(3'd1, 8'h00);

    tx_div = 4;
    wr(3'd3, 8'h04);
    base = frames;
    txq.push_back(8'h55);
    wr(3'd1, 8'h55);
    wait_frames(base + 1, 200);
    rd(3'd0, status_m(1'b0, 1'b0, 1'b1));
    wr(3'd2, 8'h02);
    @(negedge i_clk);
    check("int_txe", o_int, int_m(1'b1));
    wr(3'd2, 8'h00);
    @(negedge i_clk);
    check("int_off", o_int, int_m(1'b1));

    wr(3'd3, 8'h01);
    rd(3'd3, 8'h01);
    base = frames;
    txq.push_back(8'hF0);
    wr(3'd1, 8'hF0);
    wait_frames(base + 1, 200);

    wr(3'd3, 8'hD9);
    send(8'hA3, 1'b1, 217);
    rd(3'd0, 8'h08);
    wr(3'd2, 8'h01);
    @(negedge i_clk);
    check("int_rx", o_int, 1);
    rd_data();
    @(negedge i_clk);
    check("int_rx_clr", o_int, int_m(1'b1));
    rd(3'd0, status_m(1'b0, 1'b0, 1'b1));
    wr(3'd2, 8'h00);

    send(8'h11, 1'b1, 217);
    send(8'h22, 1'b1, 217);
    send(8'h33, 1'b1, 217);
    rd(3'd0, 8'h4C);
    wr(3'd2, 8'h04);
    @(negedge i_clk);
    check("int_err", o_int, int_m(1'b1));
    wr(3'd0, 8'h40);
    @(negedge i_clk);
    check("int_err_clr", o_int, int_m(1'b1));
    rd(3'd0, 8'h0C);
    rd_data();
    rd_data();
    rd_data();
    rd(3'd0, status_m(1'b0, 1'b0, 1'b1));
    wr(3'd2, 8'h00);

    send(8'h5A, 1'b0, 217);
    rd(3'd0, 8'h8A);
    wr(3'd0, 8'h80);
    rd(3'd0, status_m(1'b0, 1'b0, 1'b1));
    @(negedge i_clk);
    i_uart_rx = 1'b0;
    @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (400) @(negedge i_clk);
    rd(3'd0, 8'h0A);
    rd_data();

    tx_div = 8;
    wr(3'd3, 8'h08);
    base = frames;
    gapchk = 1'b1;
    burst = 0;
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'hA0 + i);
      if (i < 9) txq.push_back(b);
      wr(3'd1, b);
    end
    rd(3'd0, 8'h32);
    wait_frames(base + 9, 9 * 80 + 200);
    gapchk = 1'b0;
    repeat (50) @(negedge i_clk);
    check("txq_left", txq.size(), 0);
    rd(3'd0, 8'h0A);

    base = frames;
    txq.push_back(8'hC3);
    txq.push_back(8'h3C);
    wr(3'd1, 8'hC3);
    wr(3'd1, 8'h3C);
    repeat (30) @(negedge i_clk);
    @(posedge i_clk);
    #1 i_reset = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("mid_rst_tx", o_uart_tx, 1);
    check("mid_rst_ack", o_ack, 0);
    check("mid_rst_int", o_int, 0);
    #1 i_reset = 1'b0;
    txq.delete();
    rxq.delete();
    ferr_m = 1'b0; ovr_m = 1'b0; ie_m = 3'b0;
    rd(3'd0, 8'h0A);
    rd(3'd3, 8'hD9);
    repeat (300) @(negedge i_clk);
    check("tx_after_rst", frames, base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
